// File: rtl/frame_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_scanout_reader
// Description : VGA 640x480@60 scan-out engine. Generates raster timing at
//               the pixel clock, fetches the 640x400 framebuffer from SRAM
//               in raster order, and drives RGB/sync/DE to the video DAC
//               with all outputs aligned through a fixed-depth pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_scanout_reader #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int FB_ROWS    = 400,
    parameter int RD_LATENCY = 1
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic [15:0] I_SRAM_DATA,
    output logic [17:0] O_SRAM_ADDR,
    output logic        O_SRAM_READ,
    output logic        O_VIDEO_ON,
    output logic        O_HSYNC,
    output logic        O_VSYNC,
    output logic        O_DE,
    output logic [3:0]  O_R,
    output logic [3:0]  O_G,
    output logic [3:0]  O_B,
    output logic        O_FRAME_START
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_PIPE    = RD_LATENCY + 2;

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_VIS      = c_HW'(H_VISIBLE);
    localparam logic [c_HW-1:0] c_HS_START   = c_HW'(H_VISIBLE + H_FRONT);
    localparam logic [c_HW-1:0] c_HS_END     = c_HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_VIS      = c_VW'(V_VISIBLE);
    localparam logic [c_VW-1:0] c_FB_ROWS    = c_VW'(FB_ROWS);
    localparam logic [c_VW-1:0] c_VS_START   = c_VW'(V_VISIBLE + V_FRONT);
    localparam logic [c_VW-1:0] c_VS_END     = c_VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [c_HW-1:0]       r_h_cnt;
    logic [c_VW-1:0]       r_v_cnt;
    logic [17:0]           r_addr_cnt;
    logic [17:0]           r_sram_addr;
    logic                  r_read;
    logic                  r_video_on;
    logic                  r_frame_start;
    logic [RD_LATENCY-1:0] r_valid_sr;
    logic [11:0]           r_rgb;
    logic [c_PIPE-1:0]     r_hs_sr;
    logic [c_PIPE-1:0]     r_vs_sr;
    logic [c_PIPE-1:0]     r_de_sr;

    logic                  w_fetch;
    logic                  w_frame_top;
    logic                  w_hsync_raw;
    logic                  w_vsync_raw;
    logic                  w_de_raw;
    logic [17:0]           w_next_addr;
    logic                  w_unused_hi;

    // Raw raster decode of the current counter position
    assign w_fetch     = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_FB_ROWS);
    assign w_frame_top = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_hsync_raw = !((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END));
    assign w_vsync_raw = !((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END));
    assign w_de_raw    = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);

    // The first pixel of a frame always reads address 0, regardless of the
    // running counter, so the counter never needs a separate clear cycle.
    assign w_next_addr = w_frame_top ? 18'd0 : r_addr_cnt;

    // Upper nibble of the SRAM word carries no colour information
    assign w_unused_hi = ^I_SRAM_DATA[15:12];

    // Horizontal/vertical raster counters, wrapping together at frame end
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == c_V_LAST) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 1'b1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Fetch stage: read strobe, ownership flag, incremental address, frame pulse
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_sram_addr   <= '0;
            r_addr_cnt    <= '0;
            r_read        <= 1'b0;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_read        <= w_fetch;
            r_video_on    <= w_fetch;
            r_frame_start <= w_frame_top;
            if (w_fetch) begin
                r_sram_addr <= w_next_addr;
                r_addr_cnt  <= w_next_addr + 1'b1;
            end else if (w_frame_top) begin
                r_addr_cnt  <= '0;
            end
        end
    end

    // Data stage: track which SRAM return slots hold real pixels, then register RGB
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_valid_sr <= '0;
            r_rgb      <= '0;
        end else begin
            r_valid_sr[0] <= r_read;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid_sr[i] <= r_valid_sr[i-1];
            end
            r_rgb <= r_valid_sr[RD_LATENCY-1] ? I_SRAM_DATA[11:0] : 12'h000;
        end
    end

    // Delay sync and DE by the full fetch+data pipeline depth so they line up with RGB
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_hs_sr <= '1;
            r_vs_sr <= '1;
            r_de_sr <= '0;
        end else begin
            r_hs_sr[0] <= w_hsync_raw;
            r_vs_sr[0] <= w_vsync_raw;
            r_de_sr[0] <= w_de_raw;
            for (int i = 1; i < c_PIPE; i++) begin
                r_hs_sr[i] <= r_hs_sr[i-1];
                r_vs_sr[i] <= r_vs_sr[i-1];
                r_de_sr[i] <= r_de_sr[i-1];
            end
        end
    end

    assign O_SRAM_ADDR   = r_sram_addr;
    assign O_SRAM_READ   = r_read;
    assign O_VIDEO_ON    = r_video_on;
    assign O_FRAME_START = r_frame_start;
    assign O_HSYNC       = r_hs_sr[c_PIPE-1];
    assign O_VSYNC       = r_vs_sr[c_PIPE-1];
    assign O_DE          = r_de_sr[c_PIPE-1];
    assign O_R           = r_rgb[11:8];
    assign O_G           = r_rgb[7:4];
    assign O_B           = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_frame_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_scanout_reader
// Description : Self-checking bench. Instance A uses full VGA geometry with
//               read latency 1; instance B uses a shrunken geometry with read
//               latency 2 so whole frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scanout_reader;

    localparam int A_L = 1;
    localparam int B_L = 2;

    typedef struct packed {
        logic [17:0] addr;
        logic        rd;
        logic        von;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] salt = 16'h0000;

    logic [15:0] a_data, b_data;
    logic [17:0] a_addr, b_addr;
    logic        a_rd, a_von, a_hs, a_vs, a_de, a_fs;
    logic        b_rd, b_von, b_hs, b_vs, b_de, b_fs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int edges = 0;

    int a_hs_low, a_hs_first, a_de_cnt;
    int b_rdcnt, b_vs_low, b_de_cnt, b_fs_cnt, b_fs_k0, b_fs_k1;
    logic [17:0] b_last;

    always #5 clk = ~clk;

    frame_scanout_reader #(.RD_LATENCY(A_L)) u_a (
        .I_CLK(clk), .I_RST(rst), .I_SRAM_DATA(a_data),
        .O_SRAM_ADDR(a_addr), .O_SRAM_READ(a_rd), .O_VIDEO_ON(a_von),
        .O_HSYNC(a_hs), .O_VSYNC(a_vs), .O_DE(a_de),
        .O_R(a_r), .O_G(a_g), .O_B(a_b), .O_FRAME_START(a_fs)
    );

    frame_scanout_reader #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .FB_ROWS(8), .RD_LATENCY(B_L)
    ) u_b (
        .I_CLK(clk), .I_RST(rst), .I_SRAM_DATA(b_data),
        .O_SRAM_ADDR(b_addr), .O_SRAM_READ(b_rd), .O_VIDEO_ON(b_von),
        .O_HSYNC(b_hs), .O_VSYNC(b_vs), .O_DE(b_de),
        .O_R(b_r), .O_G(b_g), .O_B(b_b), .O_FRAME_START(b_fs)
    );

    // Expected outputs after k clock edges since reset release, from raster rules
    function automatic obs_t model(input int kk, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int fb, input int lat,
                                   input logic [15:0] s);
        int ht, vt, pipe, q, h, v;
        logic [15:0] d;
        obs_t e;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        pipe = lat + 2;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (kk >= 1) begin
            q = (kk - 1) % (ht * vt);
            h = q % ht;
            v = q / ht;
            e.rd  = (h < hv) && (v < fb);
            e.von = e.rd;
            e.fs  = (q == 0);
            if (v < fb) e.addr = 18'(v * hv + ((h < hv) ? h : hv - 1));
            else        e.addr = 18'(fb * hv - 1);
        end
        if (kk >= pipe) begin
            q = (kk - pipe) % (ht * vt);
            h = q % ht;
            v = q / ht;
            e.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
            e.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
            e.de = (h < hv) && (v < vv);
            if ((h < hv) && (v < fb)) begin
                d = 16'(v * hv + h) ^ s;
                e.rgb = d[11:0];
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] sram_word(input logic [17:0] a, input logic rd);
        logic [15:0] w;
        w = 16'($urandom);
        if (rd === 1'b1) w[11:0] = a[11:0] ^ salt[11:0];
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    task automatic wait_k(input int target);
        int n = 0;
        while (k != target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (k != target) begin
            total++;
            bad++;
            $display("FAIL wait_k k=%0d required=%0d", k, target);
        end
    endtask

    // SRAM model for A: return data RD_LATENCY cycles after the registered address
    initial begin
        logic [17:0] ha[4];
        logic        hr[4];
        a_data = 16'h0;
        for (int i = 0; i < 4; i++) begin ha[i] = '0; hr[i] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int i = 3; i > 0; i--) begin ha[i] = ha[i-1]; hr[i] = hr[i-1]; end
            ha[0] = a_addr;
            hr[0] = a_rd;
            @(posedge clk);
            #1;
            a_data = sram_word(ha[A_L-1], hr[A_L-1]);
        end
    end

    // SRAM model for B
    initial begin
        logic [17:0] ha[4];
        logic        hr[4];
        b_data = 16'h0;
        for (int i = 0; i < 4; i++) begin ha[i] = '0; hr[i] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int i = 3; i > 0; i--) begin ha[i] = ha[i-1]; hr[i] = hr[i-1]; end
            ha[0] = b_addr;
            hr[0] = b_rd;
            @(posedge clk);
            #1;
            b_data = sram_word(ha[B_L-1], hr[B_L-1]);
        end
    end

    // Edges since reset release
    always @(posedge clk) begin
        edges <= edges + 1;
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Per-cycle comparison against the model, plus window statistics
    always @(negedge clk) begin
        obs_t ea, eb, oa, ob;
        if (edges > 0) begin
            ea = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 400, A_L, salt);
            eb = model(k, 16, 2, 4, 3, 12, 1, 2, 2, 8, B_L, salt);
            oa = {a_addr, a_rd, a_von, a_fs, a_hs, a_vs, a_de, a_r, a_g, a_b};
            ob = {b_addr, b_rd, b_von, b_fs, b_hs, b_vs, b_de, b_r, b_g, b_b};
            chk("cycle_A", 64'(oa), 64'(ea));
            chk("cycle_B", 64'(ob), 64'(eb));
        end
        if (k == 0) begin
            a_hs_low = 0; a_hs_first = 0; a_de_cnt = 0;
            b_rdcnt = 0; b_vs_low = 0; b_de_cnt = 0; b_fs_cnt = 0;
            b_fs_k0 = 0; b_fs_k1 = 0; b_last = '0;
        end else begin
            if (k <= 800 && !a_hs) begin
                a_hs_low++;
                if (a_hs_first == 0) a_hs_first = k;
            end
            if (k >= 3 && k < 803 && a_de) a_de_cnt++;
            if (k <= 425 && b_rd) begin b_rdcnt++; b_last = b_addr; end
            if (k >= 4 && k < 429) begin
                if (!b_vs) b_vs_low++;
                if (b_de)  b_de_cnt++;
            end
            if (k <= 850 && b_fs) begin
                if (b_fs_cnt == 0) b_fs_k0 = k;
                else               b_fs_k1 = k;
                b_fs_cnt++;
            end
        end
    end

    // Literal checks following one reset release
    task automatic run_phase(input bit first);
        wait_k(1);
        chk("release_A", {a_addr, a_rd, a_von, a_fs}, {18'd0, 3'b111});
        chk("release_B", {b_addr, b_rd, b_von, b_fs}, {18'd0, 3'b111});
        wait_k(2);
        chk("fs_low", {a_fs, b_fs}, 2'b00);
        wait_k(229);
        chk("b_row9_fetch", {b_rd, b_von, b_addr}, {2'b00, 18'd127});
        wait_k(232);
        chk("b_row9_pixel", {b_de, b_r, b_g, b_b}, {1'b1, 12'h000});
        wait_k(810);
        chk("a_hsync_low", 64'(a_hs_low), 64'd96);
        chk("a_hsync_fall", 64'(a_hs_first), 64'd659);
        chk("a_de_line", 64'(a_de_cnt), 64'd640);
        wait_k(860);
        chk("b_reads", 64'(b_rdcnt), 64'd128);
        chk("b_last_addr", 64'(b_last), 64'd127);
        chk("b_vsync_low", 64'(b_vs_low), 64'd50);
        chk("b_de_frame", 64'(b_de_cnt), 64'd192);
        chk("b_fs_count", 64'(b_fs_cnt), 64'd2);
        chk("b_fs_period", 64'(b_fs_k1 - b_fs_k0), 64'd425);
        if (first) begin
            wait_k(1606);
            chk("a_pix_addr", {a_addr, a_rd}, {18'd1285, 1'b1});
            wait_k(1608);
            chk("a_pix_rgb", {a_de, a_r, a_g, a_b}, {1'b1, 12'h505});
        end
    endtask

    initial begin
        rst  = 1'b1;
        salt = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_state_A", {a_addr, a_rd, a_von, a_fs, a_hs, a_vs, a_de, a_r, a_g, a_b},
            {18'd0, 3'b000, 2'b11, 1'b0, 12'h000});
        chk("rst_state_B", {b_addr, b_rd, b_von, b_fs, b_hs, b_vs, b_de, b_r, b_g, b_b},
            {18'd0, 3'b000, 2'b11, 1'b0, 12'h000});
        rst = 1'b0;
        run_phase(1'b1);
        for (int it = 0; it < 4; it++) begin
            wait_k(k + $urandom_range(1, 700));
            rst = 1'b1;
            @(negedge clk);
            salt = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rst_mid_B", {b_addr, b_rd, b_hs, b_vs, b_de}, {18'd0, 1'b0, 2'b11, 1'b0});
            rst = 1'b0;
            run_phase(1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
